// File: rtl/cell_processor_pipe_pkg.sv
// Shared types, geometry constants and the cell ALU for the pipelined cell processor.
// Build option: define CELL_PROC_SAT_EN to saturate ADD/ADDI/SUB/SUBI instead of wrapping.
package cell_processor_pipe_pkg;

    localparam int unsigned CHANNEL_DEPTH = 8;
    localparam int unsigned CELL_DIM      = 3;
    localparam int unsigned CENTRE_PIXEL  = CELL_DIM / 2;

    typedef logic [CHANNEL_DEPTH-1:0] pixel_t;
    typedef logic [CELL_DIM-1:0][CELL_DIM-1:0][CHANNEL_DEPTH-1:0] cell_t;

    typedef enum logic [3:0] {
        OpAdd  = 4'h0,
        OpAddi = 4'h1,
        OpSub  = 4'h2,
        OpSubi = 4'h3,
        OpMax  = 4'h4,
        OpMin  = 4'h5,
        OpAvg  = 4'h6
    } opcode_e;

    typedef struct packed {
        opcode_e opcode;
        cell_t   cell_a;
        cell_t   cell_b;
        pixel_t  user_input_a;
    } instruction_t;

    // Layout doubles as the result FIFO entry: {data, ovf, illegal}.
    typedef struct packed {
        pixel_t data;
        logic   ovf;
        logic   illegal;
    } alu_res_t;

    localparam int unsigned RES_W = $bits(alu_res_t);

    function automatic pixel_t centre_of(cell_t c);
        return c[CENTRE_PIXEL][CENTRE_PIXEL];
    endfunction

    function automatic alu_res_t cell_alu(opcode_e op, pixel_t a, pixel_t b, pixel_t u);
        logic [CHANNEL_DEPTH:0] wide;
        pixel_t                 rhs;
        alu_res_t               res;
        res  = '0;
        res.data = a;
        rhs  = (op == OpAddi || op == OpSubi) ? u : b;
        wide = '0;
        case (op)
            OpAdd, OpAddi: begin
                wide     = {1'b0, a} + {1'b0, rhs};
                res.ovf  = wide[CHANNEL_DEPTH];
                res.data = wide[CHANNEL_DEPTH-1:0];
`ifdef CELL_PROC_SAT_EN
                if (res.ovf) res.data = '1;
`endif
            end
            OpSub, OpSubi: begin
                // Bit CHANNEL_DEPTH of the difference is the borrow, i.e. a negative result.
                wide     = {1'b0, a} - {1'b0, rhs};
                res.ovf  = wide[CHANNEL_DEPTH];
                res.data = wide[CHANNEL_DEPTH-1:0];
`ifdef CELL_PROC_SAT_EN
                if (res.ovf) res.data = '0;
`endif
            end
            OpMax: res.data = (a > b) ? a : b;
            OpMin: res.data = (a < b) ? a : b;
            OpAvg: begin
                wide     = {1'b0, a} + {1'b0, b};
                res.data = wide[CHANNEL_DEPTH:1];
            end
            default: res.illegal = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cell_result_fifo.sv
// Result buffer for the cell processor; pop on empty is ignored, push+pop on full is legal.
module cell_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/cell_processor_pipe.sv
// Two-stage pipelined cell ALU with valid/ready input and a credit-checked output FIFO.
// Build option: CELL_PROC_SAT_EN (see package) selects saturating add/sub results.
module cell_processor_pipe
    import cell_processor_pipe_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  instruction_t             in_iw,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHANNEL_DEPTH-1:0] out_data,
    output logic [1:0]               out_flags,
    output logic [CNT_W-1:0]         op_count
);

    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FIFO_CNT_W:0] DEPTH_W = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

    logic                  ready_en_q;
    logic                  s1_valid_q;
    opcode_e               s1_op_q;
    pixel_t                s1_a_q, s1_b_q, s1_u_q;
    logic                  s2_valid_q;
    alu_res_t              s2_res_q;
    logic [CNT_W-1:0]      op_count_q, op_count_d;

    alu_res_t              fifo_head;
    logic [RES_W-1:0]      fifo_head_raw;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [FIFO_CNT_W:0]   in_flight;
    logic                  accept;
    logic                  unused_iw;

    // Only the centre pixels are consumed; the rest of each cell is deliberately ignored.
    assign unused_iw = ^in_iw;

    // Every in-flight instruction already owns a FIFO slot, so a result is never dropped.
    always_comb begin
        in_flight = {1'b0, fifo_count}
                  + {{FIFO_CNT_W{1'b0}}, s1_valid_q}
                  + {{FIFO_CNT_W{1'b0}}, s2_valid_q};
        in_ready   = ready_en_q && (in_flight < DEPTH_W);
        accept     = in_valid && in_ready;
        op_count_d = op_count_q + CNT_W'(accept);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            ready_en_q <= 1'b1;
            op_count_q <= op_count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OpAdd;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_u_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_op_q <= in_iw.opcode;
                s1_a_q  <= centre_of(in_iw.cell_a);
                s1_b_q  <= centre_of(in_iw.cell_b);
                s1_u_q  <= in_iw.user_input_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) s2_res_q <= cell_alu(s1_op_q, s1_a_q, s1_b_q, s1_u_q);
        end
    end

    cell_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s2_valid_q),
        .push_data (s2_res_q),
        .pop       (out_ready),
        .head      (fifo_head_raw),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        fifo_head = alu_res_t'(fifo_head_raw);
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? '1 : fifo_head.data;
        out_flags = fifo_empty ? 2'b00 : {fifo_head.ovf, fifo_head.illegal};
        op_count  = op_count_q;
    end

endmodule

// File: tb/tb_cell_processor_pipe.sv
// Directed self-checking bench for cell_processor_pipe; honours CELL_PROC_SAT_EN if defined.
module tb_cell_processor_pipe;
    import cell_processor_pipe_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    instruction_t      in_iw;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [1:0]        out_flags;
    logic [15:0]       op_count;

    int checks;
    int passed;
    logic [15:0] exp_cnt;

    cell_processor_pipe #(
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_iw     (in_iw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instruction_t mk_iw(logic [3:0] op, logic [7:0] a, logic [7:0] b,
                                           logic [7:0] u);
        instruction_t iw;
        iw.opcode = opcode_e'(op);
        for (int r = 0; r < CELL_DIM; r++) begin
            for (int c = 0; c < CELL_DIM; c++) begin
                iw.cell_a[r][c] = 8'hA5;
                iw.cell_b[r][c] = 8'h5A;
            end
        end
        iw.cell_a[CENTRE_PIXEL][CENTRE_PIXEL] = a;
        iw.cell_b[CENTRE_PIXEL][CENTRE_PIXEL] = b;
        iw.user_input_a = u;
        return iw;
    endfunction

    // Reference model on plain integers: returns {data, ovf, illegal}.
    function automatic logic [9:0] model(logic [3:0] op, int a, int b, int u);
        int r;
        logic ovf;
        logic [7:0] d;
        ovf = 1'b0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a + u;
            4'd2: r = a - b;
            4'd3: r = a - u;
            4'd4: r = (a > b) ? a : b;
            4'd5: r = (a < b) ? a : b;
            4'd6: r = (a + b) / 2;
            default: return {a[7:0], 2'b01};
        endcase
        if (r < 0 || r > 255) ovf = 1'b1;
`ifdef CELL_PROC_SAT_EN
        if (r > 255) d = 8'hFF;
        else if (r < 0) d = 8'h00;
        else d = r[7:0];
`else
        d = r[7:0];
`endif
        return {d, ovf, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_iw = '0;
        #3 rst = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else passed++;
        checks++; if (out_data !== 8'hFF) $display("FAIL reset_out_data got %h want ff", out_data);
        else passed++;
        checks++; if (out_flags !== 2'b00) $display("FAIL reset_flags got %b want 00", out_flags);
        else passed++;
        checks++; if (op_count !== 16'd0) $display("FAIL reset_op_count got %0d want 0", op_count);
        else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready);
        else passed++;
        rst = 1'b1;
        exp_cnt = '0;
        tick();
        checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_add_latency();
        logic [7:0] exp_d;
`ifdef CELL_PROC_SAT_EN
        exp_d = 8'hFF;
`else
        exp_d = 8'h2C;
`endif
        in_iw = mk_iw(4'd0, 8'd200, 8'd100, 8'h33);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; exp_cnt++;
        checks++; if (out_valid !== 1'b0) $display("FAIL add_lat_n got %b want 0", out_valid);
        else passed++;
        checks++; if (op_count !== exp_cnt) $display("FAIL add_count got %0d want %0d", op_count, exp_cnt);
        else passed++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL add_lat_n1 got %b want 0", out_valid);
        else passed++;
        tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL add_lat_n2 got %b want 1", out_valid);
        else passed++;
        checks++; if (out_data !== exp_d) $display("FAIL add_data got %h want %h", out_data, exp_d);
        else passed++;
        checks++; if (out_flags !== 2'b10) $display("FAIL add_flags got %b want 10", out_flags);
        else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL add_popped got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_ops();
        logic [3:0] ops  [9] = '{4'd3, 4'd6, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd2, 4'd0};
        logic [7:0] av   [9] = '{8'd5, 8'd255, 8'd10, 8'd100, 8'd7, 8'd7, 8'd3, 8'd0, 8'd255};
        logic [7:0] bv   [9] = '{8'd77, 8'd255, 8'd77, 8'd30, 8'd200, 8'd200, 8'd4, 8'd1, 8'd1};
        logic [7:0] uv   [9] = '{8'd9, 8'h33, 8'd20, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
`ifdef CELL_PROC_SAT_EN
        logic [7:0] ed   [9] = '{8'h00, 8'hFF, 8'h1E, 8'h46, 8'hC8, 8'h07, 8'h03, 8'h00, 8'hFF};
`else
        logic [7:0] ed   [9] = '{8'hFC, 8'hFF, 8'h1E, 8'h46, 8'hC8, 8'h07, 8'h03, 8'hFF, 8'h00};
`endif
        logic [1:0] ef   [9] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
        for (int i = 0; i < 9; i++) begin
            in_iw = mk_iw(ops[i], av[i], bv[i], uv[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0; exp_cnt++;
            tick(); tick();
            checks++; if (out_valid !== 1'b1) $display("FAIL op%0d_valid got %b want 1", i, out_valid);
            else passed++;
            checks++;
            if (out_data !== ed[i]) $display("FAIL op%0d_data got %h want %h", i, out_data, ed[i]);
            else passed++;
            checks++;
            if (out_flags !== ef[i]) $display("FAIL op%0d_flags got %b want %b", i, out_flags, ef[i]);
            else passed++;
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    task automatic test_illegal();
        in_iw = mk_iw(4'hF, 8'h3C, 8'h99, 8'h11);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; exp_cnt++;
        checks++; if (op_count !== exp_cnt) $display("FAIL ill_count got %0d want %0d", op_count, exp_cnt);
        else passed++;
        tick(); tick();
        checks++; if (out_data !== 8'h3C) $display("FAIL ill_data got %h want 3c", out_data);
        else passed++;
        checks++; if (out_flags !== 2'b01) $display("FAIL ill_flags got %b want 01", out_flags);
        else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int k;
        k = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_iw = mk_iw(4'd1, 8'(k * 10), 8'h77, 8'd1);
            in_valid = 1'b1;
            if (in_ready) begin
                k++; exp_cnt++;
            end
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        checks++; if (k !== 4) $display("FAIL bp_accepted got %0d want 4", k);
        else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready);
        else passed++;
        checks++; if (op_count !== exp_cnt) $display("FAIL bp_count got %0d want %0d", op_count, exp_cnt);
        else passed++;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(j * 10 + 1))
                $display("FAIL bp_drain%0d got v=%b d=%h want v=1 d=%h", j, out_valid, out_data,
                         8'(j * 10 + 1));
            else passed++;
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_stream();
        logic [9:0] exp_q [$];
        logic [3:0] op;
        logic [7:0] a, b, u;
        int sent, rcv, stalls, gaps, cyc;
        sent = 0; rcv = 0; stalls = 0; gaps = 0; cyc = 0;
        out_ready = 1'b1;
        op = 4'($urandom_range(0, 7)); if (op == 4'd7) op = 4'hF;
        a = 8'($urandom); b = 8'($urandom); u = 8'($urandom);
        in_iw = mk_iw(op, a, b, u);
        in_valid = 1'b1;
        while (rcv < 100 && cyc < 400) begin
            if (!out_valid && rcv > 0) gaps++;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) $display("FAIL stream_extra got d=%h want none", out_data);
                else if ({out_data, out_flags} !== exp_q[0])
                    $display("FAIL stream%0d got %h/%b want %h/%b", rcv, out_data, out_flags,
                             exp_q[0][9:2], exp_q[0][1:0]);
                else passed++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                rcv++;
            end
            if (sent < 100) begin
                if (in_ready) begin
                    exp_q.push_back(model(op, int'(a), int'(b), int'(u)));
                    sent++; exp_cnt++;
                    op = 4'($urandom_range(0, 7)); if (op == 4'd7) op = 4'hF;
                    a = 8'($urandom); b = 8'($urandom); u = 8'($urandom);
                end else stalls++;
            end
            tick();
            cyc++;
            if (sent < 100) in_iw = mk_iw(op, a, b, u);
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++; if (rcv !== 100) $display("FAIL stream_count got %0d want 100", rcv);
        else passed++;
        checks++; if (stalls !== 0) $display("FAIL stream_stalls got %0d want 0", stalls);
        else passed++;
        checks++; if (gaps !== 0) $display("FAIL stream_gaps got %0d want 0", gaps);
        else passed++;
        checks++; if (op_count !== exp_cnt) $display("FAIL stream_opcnt got %0d want %0d", op_count, exp_cnt);
        else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_iw = mk_iw(4'd0, 8'(i), 8'd1, 8'h00);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL mid_queued got %b want 1", out_valid);
        else passed++;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", out_valid);
        else passed++;
        checks++; if (out_data !== 8'hFF) $display("FAIL mid_out_data got %h want ff", out_data);
        else passed++;
        checks++; if (op_count !== 16'd0) $display("FAIL mid_op_count got %0d want 0", op_count);
        else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready got %b want 0", in_ready);
        else passed++;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL mid_release got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        exp_cnt = '0;
        test_reset();
        test_add_latency();
        test_ops();
        test_illegal();
        test_backpressure();
        test_stream();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
